// File: rtl/mc_pkg.sv
// mc_pkg -- shared definitions for the multicycle controller and its datapath.
//   state_e  : controller state encodings (also visible on state_o)
//   IT_*     : instruction class codes decoded from the IR
//   PCSRC_*  : PC source mux selects
//   SRCB_*   : ALU B-operand mux selects
//   ALU_ADD  : ALU opcode used for PC increment and address calculation
//   ctrl_t   : bundle of every control output, in port order
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [2:0] IT_ALU_REG = 3'd0;
  localparam logic [2:0] IT_ALU_IMM = 3'd1;
  localparam logic [2:0] IT_LOAD    = 3'd2;
  localparam logic [2:0] IT_STORE   = 3'd3;
  localparam logic [2:0] IT_BRANCH  = 3'd4;
  localparam logic [2:0] IT_JUMP    = 3'd5;

  localparam logic [1:0] PCSRC_INC    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_TRAP   = 2'd2;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;
  localparam logic [1:0] SRCB_ONE = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;

  localparam logic [1:0] COND_ALWAYS = 2'd0;
  localparam logic [1:0] COND_Z      = 2'd1;
  localparam logic [1:0] COND_N      = 2'd2;
  localparam logic [1:0] COND_V      = 2'd3;

  typedef struct packed {
    logic [2:0] aluoperation;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       mems;
    logic       memread;
    logic       memwrite;
    logic       loadir;
    logic       regwrite;
    logic       srca;
    logic       loadf;
    logic [1:0] srcb;
    logic       irq_ack;
    logic       bus_err;
  } ctrl_t;

  // Classes 6 and 7 are unassigned and must trap.
  function automatic logic is_illegal(input logic [2:0] it);
    return it > IT_JUMP;
  endfunction

  function automatic logic branch_taken(input logic [1:0] cond, input logic z,
                                        input logic n, input logic v);
    case (cond)
      COND_ALWAYS: return 1'b1;
      COND_Z:      return z;
      COND_N:      return n;
      default:     return v;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer -- counts consecutive memory wait cycles.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the count (controller changed state)
//   en       : this cycle is a wait cycle (memory not ready)
//   expired  : count has reached MEM_TIMEOUT
// The count saturates at MEM_TIMEOUT; TW must be wide enough that
// 2**TW > MEM_TIMEOUT.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is judged against the registered count, so a mem_ready arriving
  // in the same cycle the count reaches the limit still wins.
  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl -- multicycle CPU control unit.
//   clk, rst        : clock, synchronous active-high reset
//   it, opc, C      : instruction class, ALU opcode, branch condition from IR
//   z, n, v         : registered datapath flags
//   mem_ready       : memory completes the current access this cycle
//   irq             : level interrupt request
//   aluoperation, pcsrc, pcwrite, mems, memread, memwrite, loadir,
//   regwrite, srca, loadf, srcb : datapath controls (combinational)
//   irq_ack, bus_err : one-cycle event pulses
//   state_o          : current state encoding
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter bit IRQ_EN      = 1'b1,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] it,
  input  logic [2:0] opc,
  input  logic [1:0] C,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  input  logic       mem_ready,
  input  logic       irq,
  output logic [2:0] aluoperation,
  output logic [1:0] pcsrc,
  output logic       pcwrite,
  output logic       mems,
  output logic       memread,
  output logic       memwrite,
  output logic       loadir,
  output logic       regwrite,
  output logic       srca,
  output logic       loadf,
  output logic [1:0] srcb,
  output logic       irq_ack,
  output logic       bus_err,
  output logic [2:0] state_o
);

  state_e state_q, state_d;
  // Set on every FETCH entry except the one straight out of TRAP, so a
  // still-asserted irq cannot trap again before one instruction runs.
  logic   entry_q, entry_d;
  logic   expired;
  logic   timer_en, timer_clr;
  ctrl_t  ctl;
  ctrl_t  ctl_o;

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (IRQ_EN && entry_q && irq) begin
          ctl.irq_ack = 1'b1;
          state_d     = ST_TRAP;
        end else if (mem_ready) begin
          ctl.memread      = 1'b1;
          ctl.loadir       = 1'b1;
          ctl.pcwrite      = 1'b1;
          ctl.pcsrc        = PCSRC_INC;
          ctl.srcb         = SRCB_ONE;
          ctl.aluoperation = ALU_ADD;
          state_d          = ST_DECODE;
        end else if (expired) begin
          ctl.bus_err = 1'b1;
          state_d     = ST_TRAP;
        end else begin
          ctl.memread = 1'b1;
        end
      end
      ST_DECODE: begin
        if (it == IT_JUMP) begin
          ctl.pcwrite = 1'b1;
          ctl.pcsrc   = PCSRC_BRANCH;
          state_d     = ST_FETCH;
        end else if (is_illegal(it)) begin
          ctl.bus_err = 1'b1;
          state_d     = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (it)
          IT_ALU_REG, IT_ALU_IMM: begin
            ctl.aluoperation = opc;
            ctl.srca         = 1'b1;
            ctl.srcb         = (it == IT_ALU_IMM) ? SRCB_IMM : SRCB_REG;
            ctl.loadf        = 1'b1;
            state_d          = ST_WB;
          end
          IT_LOAD, IT_STORE: begin
            ctl.aluoperation = ALU_ADD;
            ctl.srca         = 1'b1;
            ctl.srcb         = SRCB_IMM;
            state_d          = ST_MEM;
          end
          IT_BRANCH: begin
            if (branch_taken(C, z, n, v)) begin
              ctl.pcwrite = 1'b1;
              ctl.pcsrc   = PCSRC_BRANCH;
            end
            state_d = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        ctl.mems = 1'b1;
        if (mem_ready || !expired) begin
          ctl.memread  = (it == IT_LOAD);
          ctl.memwrite = (it != IT_LOAD);
          if (mem_ready) begin
            state_d = (it == IT_LOAD) ? ST_WB : ST_FETCH;
          end
        end else begin
          // Timed out: abandon the access rather than keep driving it.
          ctl.bus_err = 1'b1;
          state_d     = ST_TRAP;
        end
      end
      ST_WB: begin
        ctl.regwrite = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_TRAP: begin
        ctl.pcwrite = 1'b1;
        ctl.pcsrc   = PCSRC_TRAP;
        state_d     = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    entry_d = entry_q;
    if (state_q == ST_FETCH) begin
      entry_d = 1'b0;
    end
    if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
      entry_d = (state_q != ST_TRAP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      entry_q <= 1'b1;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  assign timer_en  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  assign timer_clr = (state_d != state_q);

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TW         (TW)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(expired)
  );

  // Outputs are forced quiet while reset is held so no access can leak out.
  assign ctl_o        = rst ? '0 : ctl;
  assign aluoperation = ctl_o.aluoperation;
  assign pcsrc        = ctl_o.pcsrc;
  assign pcwrite      = ctl_o.pcwrite;
  assign mems         = ctl_o.mems;
  assign memread      = ctl_o.memread;
  assign memwrite     = ctl_o.memwrite;
  assign loadir       = ctl_o.loadir;
  assign regwrite     = ctl_o.regwrite;
  assign srca         = ctl_o.srca;
  assign loadf        = ctl_o.loadf;
  assign srcb         = ctl_o.srcb;
  assign irq_ack      = ctl_o.irq_ack;
  assign bus_err      = ctl_o.bus_err;
  assign state_o      = rst ? ST_FETCH : state_q;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max consecutive memory wait cycles before bus error (range 1..255).
REQ-002 Parameter IRQ_EN, default 1, 1 = interrupt sampling enabled, 0 = irq ignored.
REQ-003 Parameter TW, default 8, width of internal wait counter; SHALL satisfy 2^TW > MEM_TIMEOUT.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 it  in  3  instruction class from IR: 0 ALU-reg, 1 ALU-imm, 2 load, 3 store, 4 cond branch, 5 jump, 6-7 illegal.
REQ-007 opc  in  3  ALU opcode from IR.
REQ-008 C  in  2  branch condition: 0 always, 1 z, 2 n, 3 v.
REQ-009 z, n, v  in  1 each  registered flags from datapath.
REQ-010 mem_ready  in  1  memory completes current access this cycle.
REQ-011 irq  in  1  level interrupt request.
REQ-012 aluoperation  out  3; pcsrc  out  2 (0 PC+1, 1 branch target, 2 trap vector); pcwrite, mems, memread, memwrite, loadir, regwrite, srca, loadf  out  1 each; srcb  out  2 (0 reg, 1 imm, 2 const 1).
REQ-013 irq_ack  out  1  one-cycle pulse when interrupt taken.
REQ-014 bus_err  out  1  one-cycle pulse on memory timeout or illegal class.
REQ-015 state_o  out  3  current state encoding, for debug.

Function
REQ-016 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; one state per cycle except FETCH/MEM wait.
REQ-017 FETCH: memread=1, mems=0; while mem_ready=0 stay; on mem_ready=1 assert loadir, pcwrite, pcsrc=0, srca=0, srcb=2, aluoperation=ADD, go DECODE.
REQ-018 On entry to FETCH with IRQ_EN=1 and irq=1, SHALL go TRAP instead of starting fetch, pulsing irq_ack.
REQ-019 DECODE: it 0,1 -> EXEC; 2,3 -> EXEC (address calc); 4 -> EXEC; 5 -> pcwrite, pcsrc=1, go FETCH; 6,7 -> bus_err pulse, go TRAP.
REQ-020 EXEC ALU: aluoperation=opc, srca=1, srcb=0 (it 0) or 1 (it 1), loadf=1, go WB.
REQ-021 EXEC load/store: aluoperation=ADD, srca=1, srcb=1, go MEM.
REQ-022 EXEC branch: taken when C=0, or C=1&z, C=2&n, C=3&v; taken -> pcwrite, pcsrc=1; go FETCH either way; loadf=0.
REQ-023 MEM: mems=1; load asserts memread, store asserts memwrite; held until mem_ready=1; load -> WB, store -> FETCH.
REQ-024 WB: regwrite=1 for one cycle, go FETCH.
REQ-025 TRAP: pcwrite=1, pcsrc=2 one cycle, go FETCH; irq not re-sampled until the next FETCH entry after trap.
REQ-026 Wait counter counts consecutive mem_ready=0 cycles in FETCH or MEM, cleared on state change; when count reaches MEM_TIMEOUT with mem_ready still 0, pulse bus_err, drop memread/memwrite, go TRAP.
REQ-027 mem_ready=1 in the same cycle count reaches MEM_TIMEOUT SHALL complete normally (no error).
REQ-028 All outputs not named for a state SHALL be 0 in that state; outputs are combinational from state and inputs.
REQ-029 regwrite and memwrite SHALL never be asserted in the same cycle.

Reset
REQ-030 rst=1 at a rising edge SHALL force state FETCH, wait counter 0, interrupt-entry flag set, regardless of current state (incl. mid-MEM wait).
REQ-031 While rst=1 all outputs SHALL be 0 except state_o = FETCH encoding; no memory access is issued.

Structure
REQ-032 State encodings, it class codes, pcsrc/srcb selects and ALU ADD code SHALL live in shared package mc_pkg, also used by datapath.
REQ-033 Wait/timeout counter SHALL be a sub-module mc_wait_timer (inputs clr, en; output expired).

Verification
REQ-034 ALU-reg, mem_ready=1 always -> FETCH,DECODE,EXEC,WB,FETCH; regwrite high exactly in cycle 4, loadf in cycle 3.
REQ-035 Load, mem_ready low 3 cycles in MEM -> memread held 4 cycles, then WB; no bus_err.
REQ-036 Store, mem_ready held 0, MEM_TIMEOUT=15 -> bus_err pulse after 15th wait cycle, then TRAP with pcsrc=2, pcwrite=1.
REQ-037 Branch C=1: z=1 -> pcwrite, pcsrc=1 in EXEC; z=0 -> pcwrite=0; both return to FETCH.
REQ-038 irq=1 at FETCH entry, IRQ_EN=1 -> irq_ack pulse, TRAP; IRQ_EN=0 -> normal fetch; it=7 -> bus_err, TRAP.
REQ-039 rst asserted during MEM wait -> next cycle FETCH, memwrite 0, counter 0.
